// File: rtl/fir_axil_pkg.sv
// fir_axil_pkg: shared constants and types for the FIR AXI4-Lite register file.
//   - word-index register offsets (byte address [4:2])
//   - AXI response codes
//   - write/read channel state enums
//   - STATUS bit index and a byte-lane merge helper
package fir_axil_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;  // 0x00
  localparam logic [2:0] REG_SAMPLE = 3'd1;  // 0x04
  localparam logic [2:0] REG_COEF   = 3'd2;  // 0x08
  localparam logic [2:0] REG_CFG    = 3'd3;  // 0x0C
  localparam logic [2:0] REG_RESULT = 3'd4;  // 0x10
  localparam logic [2:0] REG_STATUS = 3'd5;  // 0x14

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_READY_BIT = 0;

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;

  // Replace only the byte lanes selected by strb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/fir_axil_regs.sv
// fir_axil_regs: AXI4-Lite slave register file in front of the FIR core.
//   ACLK/ARESETN       clock, async active-low reset
//   S_AXI_AW*/W*/B*    single-beat write channel (joint AW+W handshake)
//   S_AXI_AR*/R*       single-beat read channel
//   ctrl_o..cfg_o      RW registers 0x00..0x0C
//   sample_wr_o        one-cycle pulse after any accepted write to 0x04
//   result_i/_valid_i  FIR output capture into RESULT (0x10), sets STATUS[0]
// Optional: define FIR_AXIL_SLVERR_EN to answer SLVERR for unmapped
// addresses and for writes to the read-only registers.
module fir_axil_regs
  import fir_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   sample_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   coef_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_o,
  output logic                            sample_wr_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   result_i,
  input  logic                            result_valid_i
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  wstate_e            w_state_q, w_state_d;
  rstate_e            r_state_q, r_state_d;
  logic [3:0][DW-1:0] regs_q, regs_d;
  logic [DW-1:0]      result_q, result_d;
  logic               result_ready_q, result_ready_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [2:0]         rsel_q, rsel_d;
  logic               sample_wr_q, sample_wr_d;

  logic               wr_hs, rd_hs;
  logic [2:0]         wr_idx, rd_idx;
  logic [DW-1:0]      rd_mux;
  logic [1:0]         wr_resp, rd_resp;

  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];

  // Ready depends on valid so the handshake is a single-cycle pulse; gated by
  // reset so nothing is accepted while ARESETN is low.
  assign wr_hs = ARESETN && (w_state_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs = ARESETN && (r_state_q == R_IDLE) && S_AXI_ARVALID;

  // PROT and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifdef FIR_AXIL_SLVERR_EN
  assign wr_resp = (wr_idx >= REG_RESULT) ? RESP_SLVERR : RESP_OKAY;
  assign rd_resp = (rd_idx >  REG_STATUS) ? RESP_SLVERR : RESP_OKAY;
`else
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      REG_CTRL, REG_SAMPLE, REG_COEF, REG_CFG: rd_mux = regs_q[rd_idx[1:0]];
      REG_RESULT: rd_mux = result_q;
      REG_STATUS: rd_mux[STATUS_READY_BIT] = result_ready_q;
      default:    rd_mux = '0;
    endcase
  end

  // Write channel
  always_comb begin
    w_state_d   = w_state_q;
    regs_d      = regs_q;
    bresp_d     = bresp_q;
    sample_wr_d = 1'b0;
    case (w_state_q)
      W_IDLE: if (wr_hs) begin
        if (wr_idx <= REG_CFG)
          regs_d[wr_idx[1:0]] = apply_wstrb(regs_q[wr_idx[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
        sample_wr_d = (wr_idx == REG_SAMPLE);
        bresp_d     = wr_resp;
        w_state_d   = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel; RDATA is captured at the AR handshake, so a write landing in
  // the same cycle is not visible in this read.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rsel_d    = rsel_q;
    case (r_state_q)
      R_IDLE: if (rd_hs) begin
        rdata_d   = rd_mux;
        rresp_d   = rd_resp;
        rsel_d    = rd_idx;
        r_state_d = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Result capture; a new result wins over the clear-on-read.
  always_comb begin
    result_d       = result_q;
    result_ready_d = result_ready_q;
    if (result_valid_i) begin
      result_d       = result_i;
      result_ready_d = 1'b1;
    end else if ((r_state_q == R_DATA) && S_AXI_RREADY && (rsel_q == REG_RESULT)) begin
      result_ready_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q      <= W_IDLE;
      r_state_q      <= R_IDLE;
      regs_q         <= '0;
      result_q       <= '0;
      result_ready_q <= 1'b0;
      bresp_q        <= RESP_OKAY;
      rdata_q        <= '0;
      rresp_q        <= RESP_OKAY;
      rsel_q         <= '0;
      sample_wr_q    <= 1'b0;
    end else begin
      w_state_q      <= w_state_d;
      r_state_q      <= r_state_d;
      regs_q         <= regs_d;
      result_q       <= result_d;
      result_ready_q <= result_ready_d;
      bresp_q        <= bresp_d;
      rdata_q        <= rdata_d;
      rresp_q        <= rresp_d;
      rsel_q         <= rsel_d;
      sample_wr_q    <= sample_wr_d;
    end
  end

  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = rd_hs;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign ctrl_o      = regs_q[0];
  assign sample_o    = regs_q[1];
  assign coef_o      = regs_q[2];
  assign cfg_o       = regs_q[3];
  assign sample_wr_o = sample_wr_q;

endmodule

// File: tb/tb_fir_axil_regs.sv
// tb_fir_axil_regs: directed + randomized bench for fir_axil_regs with a
// word-level reference model of the register map.
module tb_fir_axil_regs;

  logic        ACLK, ARESETN;
  logic [4:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] ctrl_o, sample_o, coef_o, cfg_o, result_i;
  logic        sample_wr_o, result_valid_i;

  fir_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .ctrl_o(ctrl_o), .sample_o(sample_o), .coef_o(coef_o), .cfg_o(cfg_o),
    .sample_wr_o(sample_wr_o), .result_i(result_i), .result_valid_i(result_valid_i)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the four RW words, the captured result, and the sticky flag.
  logic [31:0] ref_rw [4];
  logic [31:0] ref_result;
  logic        ref_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0, 1, 2, 3: return ref_rw[idx];
      4:          return ref_result;
      5:          return {31'd0, ref_ready};
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] model_wresp(input int idx);
`ifdef FIR_AXIL_SLVERR_EN
    return (idx >= 4) ? 2'b10 : 2'b00;
`else
    return (idx >= 0) ? 2'b00 : 2'b00;
`endif
  endfunction

  function automatic logic [1:0] model_rresp(input int idx);
`ifdef FIR_AXIL_SLVERR_EN
    return (idx >= 6) ? 2'b10 : 2'b00;
`else
    return (idx >= 0) ? 2'b00 : 2'b00;
`endif
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < 4)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_rw[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_rw[i] = 32'd0;
    ref_result = 32'd0;
    ref_ready  = 1'b0;
  endtask

  // Full write with timing checks on BVALID and sample_wr_o; updates the model.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    int idx;
    idx = int'(a[4:2]);
    @(negedge ACLK);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    AWPROT = 3'($urandom);
    #1;
    n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin @(negedge ACLK); #1; n++; end
    check("wr_handshake", {31'd0, AWREADY && WREADY}, 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    model_write(idx, d, s);
    check("bvalid_n1", {31'd0, BVALID}, 32'd1);
    check("bresp", {30'd0, BRESP}, {30'd0, model_wresp(idx)});
    check("sample_wr_n1", {31'd0, sample_wr_o}, {31'd0, idx == 1});
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("bvalid_done", {31'd0, BVALID}, 32'd0);
    check("sample_wr_n2", {31'd0, sample_wr_o}, 32'd0);
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1; ARPROT = 3'($urandom);
    #1;
    n = 0;
    while (!ARREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    check("rd_handshake", {31'd0, ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    check("rvalid_n1", {31'd0, RVALID}, 32'd1);
    d = RDATA; r = RRESP;
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    check("rvalid_done", {31'd0, RVALID}, 32'd0);
  endtask

  task automatic check_read(input logic [4:0] a, input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    int idx;
    idx = int'(a[4:2]);
    do_read(a, d, r);
    check(tag, d, model_read(idx));
    check({tag, "_resp"}, {30'd0, r}, {30'd0, model_rresp(idx)});
    if (idx == 4) ref_ready = 1'b0;
  endtask

  task automatic pulse_result(input logic [31:0] v);
    @(negedge ACLK);
    result_i = v; result_valid_i = 1'b1;
    @(negedge ACLK);
    result_valid_i = 1'b0;
    ref_result = v; ref_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0; result_i = '0; result_valid_i = 0;
    model_reset();
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", {31'd0, AWREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, RVALID},  32'd0);
    check("rst_arready", {31'd0, ARREADY}, 32'd0);
    check("rst_rdata",   RDATA, 32'd0);
    check("rst_resps",   {28'd0, BRESP, RRESP}, 32'd0);
    check("rst_ctrl",    ctrl_o | sample_o | coef_o | cfg_o, 32'd0);
    check("rst_sample_wr", {31'd0, sample_wr_o}, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // Basic write / readback
    for (int i = 0; i < 4; i++) do_write(5'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) check_read(5'(i * 4), "rw_readback");
    check("ctrl_o", ctrl_o, 32'd1);
    check("cfg_o",  cfg_o,  32'd4);

    // Byte strobes
    do_write(5'h08, 32'h0, 4'hF);
    do_write(5'h08, 32'hAABBCCDD, 4'b0101);
    check("coef_strb", coef_o, 32'h00BB00DD);
    check_read(5'h08, "strb_readback");

    // AW leads W by three cycles
    @(negedge ACLK);
    AWADDR = 5'h04; AWVALID = 1'b1; WDATA = 32'h5A5A0001; WSTRB = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("aw_only_noready", {30'd0, AWREADY, WREADY}, 32'd0);
      @(negedge ACLK);
    end
    WVALID = 1'b1;
    #1;
    check("joint_ready", {30'd0, AWREADY, WREADY}, 32'd3);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    model_write(1, 32'h5A5A0001, 4'hF);
    check("late_w_bvalid", {31'd0, BVALID}, 32'd1);
    check("late_w_sample_pulse", {31'd0, sample_wr_o}, 32'd1);
    check("sample_o", sample_o, 32'h5A5A0001);
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("late_w_sample_end", {31'd0, sample_wr_o}, 32'd0);

    // Result capture and sticky status
    pulse_result(32'h12345678);
    check_read(5'h14, "status_set");
    check_read(5'h10, "result");
    check_read(5'h14, "status_cleared");

    // New result coincident with completion of a RESULT read: set wins
    pulse_result(32'hCAFEF00D);
    @(negedge ACLK);
    ARADDR = 5'h10; ARVALID = 1'b1;
    #1;
    check("coinc_arready", {31'd0, ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    check("coinc_rdata", RDATA, 32'hCAFEF00D);
    RREADY = 1'b1; result_i = 32'h0BADBEEF; result_valid_i = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0; result_valid_i = 1'b0;
    ref_result = 32'h0BADBEEF; ref_ready = 1'b1;
    check_read(5'h14, "status_held");
    check_read(5'h10, "result_new");

    // Read back-pressure: RVALID/RDATA stable, no new AR accepted
    @(negedge ACLK);
    ARADDR = 5'h08; ARVALID = 1'b1;
    #1;
    check("bp_arready", {31'd0, ARREADY}, 32'd1);
    @(posedge ACLK); #1;
    ARADDR = 5'h0C;
    held = model_read(2);
    for (int c = 0; c < 10; c++) begin
      check("bp_rvalid", {31'd0, RVALID}, 32'd1);
      check("bp_rdata", RDATA, held);
      check("bp_no_ar", {31'd0, ARREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    ARVALID = 1'b0;
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    check("bp_done", {31'd0, RVALID}, 32'd0);

    // Unmapped read
    check_read(5'h1C, "unmapped_read");

    // Randomized traffic against the model
    for (int t = 0; t < 24; t++) begin
      int          idx;
      logic [4:0]  a;
      idx = int'($urandom_range(0, 7));
      a   = {3'(idx), 2'($urandom)};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom));
      else
        check_read(a, "rand_read");
      if ($urandom_range(0, 5) == 0) pulse_result($urandom);
    end
    check("rand_ctrl_o",   ctrl_o,   ref_rw[0]);
    check("rand_sample_o", sample_o, ref_rw[1]);
    check("rand_coef_o",   coef_o,   ref_rw[2]);
    check("rand_cfg_o",    cfg_o,    ref_rw[3]);

    // Reset while waiting for BREADY
    @(negedge ACLK);
    AWADDR = 5'h00; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    n = 0;
    while (!AWREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    check("rst_mid_bvalid_before", {31'd0, BVALID}, 32'd1);
    check("rst_mid_ctrl_before", ctrl_o, 32'hDEADBEEF);
    #2;
    ARESETN = 1'b0;
    #1;
    check("rst_mid_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_mid_ctrl", ctrl_o, 32'd0);
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_mid_no_resp", {31'd0, BVALID}, 32'd0);
    check_read(5'h00, "ctrl_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
